// File: rtl/aes_pkg.sv
// Shared AES types, SubBytes FSM encoding and S-box tables.
// The inverse table is compiled only when SUB_BYTES_DUAL_EN is defined.
package aes_pkg;

    localparam int AES_BYTES = 16;

    typedef logic [7:0] aes_byte_t;
    // Byte k of a state lives at element [AES_BYTES-1-k], i.e. byte 0 is the MS byte.
    typedef logic [AES_BYTES-1:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } sb_state_e;

    // Entry 0 occupies the top byte so the table reads like the FIPS-197 listing.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic aes_byte_t sbox_fwd(input aes_byte_t b);
        return SBOX_FWD[{~b, 3'b000} +: 8];
    endfunction

`ifdef SUB_BYTES_DUAL_EN
    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic aes_byte_t sbox_inv(input aes_byte_t b);
        return SBOX_INV[{~b, 3'b000} +: 8];
    endfunction
`endif

endpackage

// File: rtl/sbox_lane.sv
// One registered S-box lookup with a single cycle of latency, reset to 8'h00.
// With SUB_BYTES_DUAL_EN the inv input selects the inverse table.
module sbox_lane
    import aes_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
`ifdef SUB_BYTES_DUAL_EN
    input  logic      inv,
`endif
    input  aes_byte_t addr,
    output aes_byte_t data
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= 8'h00;
        end else begin
`ifdef SUB_BYTES_DUAL_EN
            data <= inv ? sbox_inv(addr) : sbox_fwd(addr);
`else
            data <= sbox_fwd(addr);
`endif
        end
    end

endmodule

// File: rtl/sub_bytes_engine.sv
// Sequential AES SubBytes: LANES registered S-box lanes walk the captured state in
// AES_BYTES/LANES groups. SUB_BYTES_DUAL_EN adds the inv_mode port and inverse lanes.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_state,
`ifdef SUB_BYTES_DUAL_EN
    input  logic       inv_mode,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_state
);

    localparam int N     = AES_BYTES / LANES;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    sb_state_e        state, state_next;
    logic [IDX_W-1:0] idx, wr_idx;
    logic             drain, wr_en, accept;
    aes_state_t       cap;
    aes_byte_t        lane_data [LANES];
`ifdef SUB_BYTES_DUAL_EN
    logic             cap_inv;
`endif

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (drain) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_next = in_valid ? LOOKUP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // drain marks the extra cycle in which the last issued group leaves the lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            drain     <= 1'b0;
            cap       <= '0;
            wr_en     <= 1'b0;
            wr_idx    <= '0;
            out_state <= '0;
`ifdef SUB_BYTES_DUAL_EN
            cap_inv   <= 1'b0;
`endif
        end else begin
            wr_en  <= (state == LOOKUP) && !drain;
            wr_idx <= idx;
            if (accept) begin
                cap   <= in_state;
                idx   <= '0;
                drain <= 1'b0;
`ifdef SUB_BYTES_DUAL_EN
                cap_inv <= inv_mode;
`endif
            end else if (state == LOOKUP && !drain) begin
                idx   <= (idx == LAST) ? '0 : idx + 1'b1;
                drain <= (idx == LAST);
            end
            if (wr_en) begin
                for (int l = 0; l < LANES; l++) begin
                    out_state[4'(AES_BYTES - 1 - (int'(wr_idx) * LANES + l))] <= lane_data[l];
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [3:0] sel;
        assign sel = 4'(int'(idx) * LANES + g);

        sbox_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
`ifdef SUB_BYTES_DUAL_EN
            .inv   (cap_inv),
`endif
            .addr  (cap[4'd15 - sel]),
            .data  (lane_data[g])
        );
    end

endmodule
